// File: rtl/aes_core_arbiter_if.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter_if
//
// Host-side bundle of the AES core arbiter: the per-requester request
// handshake (valid/ready with key and plaintext) and the per-requester
// response handshake (valid/ready with a shared ciphertext bus and error flag).
//
//   req_valid  [NREQ]       request pending, one bit per requester
//   req_ready  [NREQ]       one-hot grant/accept strobe
//   req_key    [128*NREQ]   key for requester i at [128i+127:128i]
//   req_text   [128*NREQ]   plaintext for requester i, same packing
//   resp_valid [NREQ]       one-hot result valid
//   resp_ready [NREQ]       requester accepts result
//   resp_data  [128]        ciphertext, shared by all requesters
//   resp_err   [1]          resp_data is the watchdog error result
//
// Modports: slave = arbiter side, master = requester side.
// ---------------------------------------------------------------------------
interface aes_core_arbiter_if #(
    parameter int NREQ = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [128*NREQ-1:0]   req_key;
    logic [128*NREQ-1:0]   req_text;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [127:0]          resp_data;
    logic                  resp_err;

    modport slave (
        input  req_valid,
        input  req_key,
        input  req_text,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );

    modport master (
        output req_valid,
        output req_key,
        output req_text,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// ---------------------------------------------------------------------------
// aes_core_arbiter
//
// Round-robin scheduler sharing one AES-128 cipher core among NREQ
// requesters. The winning key/plaintext pair is latched, the core is
// launched, completion is awaited under a watchdog, and the result is
// returned to the winner through its response handshake.
//
// Ports:
//   clk          single clock, rising edge
//   rst_         synchronous active-high reset
//   bus          host-side request/response bundle (slave modport)
//   core_start   one-cycle launch pulse to the cipher core
//   core_abort   one-cycle pulse on the last WAIT cycle when the watchdog fires
//   core_key     latched key, stable from LAUNCH until IDLE
//   core_text    latched plaintext, same stability
//   core_done    core completion pulse (honoured only in WAIT)
//   core_result  core ciphertext, valid with core_done
//   busy         FSM not in IDLE
//   err_cnt      saturating count of watchdog events
//
// Parameters:
//   NREQ         number of requesters, 2..4
//   TIMEOUT_CYC  WAIT cycles before the watchdog fires, 16..255
// ---------------------------------------------------------------------------
module aes_core_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_,
    aes_core_arbiter_if.slave    bus,
    output logic                 core_start,
    output logic                 core_abort,
    output logic [127:0]         core_key,
    output logic [127:0]         core_text,
    input  logic                 core_done,
    input  logic [127:0]         core_result,
    output logic                 busy,
    output logic [7:0]           err_cnt
);

    // Pointer / grant-id width: 1 bit for two requesters, 2 bits for 3..4.
    localparam int PW = (NREQ > 2) ? 2 : 1;

    // The watchdog counter holds (WAIT cycles elapsed - 1) during WAIT.
    // It equals TIMEOUT_CYC-2 one cycle before the last WAIT cycle, which is
    // when the abort strobe is armed so that it is a flop output.
    localparam logic [7:0] WD_ARM = 8'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [PW-1:0]      rr_ptr_reg;
    logic [PW-1:0]      gnt_id_reg;
    logic [7:0]         wd_cnt_reg;
    logic               abort_arm_reg;
    logic               core_start_reg;
    logic [127:0]       core_key_reg;
    logic [127:0]       core_text_reg;
    logic [NREQ-1:0]    resp_valid_reg;
    logic [127:0]       resp_data_reg;
    logic               resp_err_reg;
    logic [7:0]         err_cnt_reg;

    // Grant search results
    logic               gnt_found;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      cand;
    logic [NREQ-1:0]    gnt_onehot;
    logic [NREQ-1:0]    resp_sel;

    // Per-cycle events
    logic               req_fire;
    logic               done_hit;
    logic               timeout;
    logic               resp_fire;

    // -----------------------------------------------------------------------
    // Round-robin grant: first valid requester at or above rr_ptr, wrapping.
    // -----------------------------------------------------------------------
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr_reg) + k) % NREQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
            assign gnt_onehot[gi] = gnt_found && (gnt_idx == PW'(gi));
            assign resp_sel[gi]   = (gnt_id_reg == PW'(gi));
        end
    endgenerate

    // req_ready is combinational so a requester is accepted in the same
    // cycle it is granted; nothing is latched before that handshake.
    assign bus.req_ready = (state_reg == ST_IDLE) ? gnt_onehot : '0;

    assign req_fire  = (state_reg == ST_IDLE) && gnt_found;
    assign done_hit  = (state_reg == ST_WAIT) && core_done;
    // Completion on the expiry cycle takes priority over the watchdog.
    assign timeout   = (state_reg == ST_WAIT) && abort_arm_reg && !core_done;
    assign resp_fire = (state_reg == ST_RESP) && bus.resp_ready[gnt_id_reg];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_hit || timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            gnt_id_reg     <= '0;
            wd_cnt_reg     <= '0;
            abort_arm_reg  <= 1'b0;
            core_start_reg <= 1'b0;
            core_key_reg   <= '0;
            core_text_reg  <= '0;
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            core_start_reg <= req_fire;

            // Armed only for the final WAIT cycle; dropped if the core
            // finishes first because the FSM then leaves WAIT.
            abort_arm_reg  <= (state_reg == ST_WAIT) && !core_done
                              && (wd_cnt_reg == WD_ARM);

            if (req_fire) begin
                core_key_reg  <= bus.req_key[gnt_idx*128 +: 128];
                core_text_reg <= bus.req_text[gnt_idx*128 +: 128];
                gnt_id_reg    <= gnt_idx;
                wd_cnt_reg    <= '0;
            end else if (state_reg == ST_WAIT) begin
                wd_cnt_reg    <= wd_cnt_reg + 8'd1;
            end

            if (done_hit) begin
                resp_data_reg  <= core_result;
                resp_err_reg   <= 1'b0;
                resp_valid_reg <= resp_sel;
            end else if (timeout) begin
                resp_data_reg  <= '0;
                resp_err_reg   <= 1'b1;
                resp_valid_reg <= resp_sel;
                if (err_cnt_reg != 8'hFF) begin
                    err_cnt_reg <= err_cnt_reg + 8'd1;
                end
            end

            if (resp_fire) begin
                resp_valid_reg <= '0;
                if (gnt_id_reg == PW'(NREQ - 1)) begin
                    rr_ptr_reg <= '0;
                end else begin
                    rr_ptr_reg <= gnt_id_reg + PW'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_err   = resp_err_reg;
    assign core_start     = core_start_reg;
    assign core_abort     = timeout;
    assign core_key       = core_key_reg;
    assign core_text      = core_text_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign err_cnt        = err_cnt_reg;

endmodule
